pass_scheduler: RTL and testbench
=================================

# pass_scheduler

Layer-level sequencer that sits above the per-pass PE-array controller. It splits one convolution/linear layer into `num_m_tiles × num_c_tiles` passes and, for each pass, drives the pass controller's configuration and base-address inputs, pulses its start bit and waits for its `done`. The first input-channel pass of each output-channel tile loads bias; later passes accumulate partial sums from the opsum region.

## Interface
- `TILE_BITS`, default 8: width of the tile-count and tile-index fields.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `layer_start` in 1: start a layer; sampled only in IDLE.
- `op_config`, `mapping_param`, `shape_param1`, `shape_param2` in 32 each: layer configuration; latched at start.
- `num_m_tiles`, `num_c_tiles` in TILE_BITS each: output-channel and input-channel pass counts; latched at start.
- `filter_base`, `ifmap_base`, `bias_base`, `opsum_base` in 32 each: layer region bases; latched at start.
- `filter_tile_bytes`, `ifmap_tile_bytes`, `bias_tile_bytes`, `opsum_tile_bytes` in 32 each: per-tile strides; latched at start.
- `pass_done` in 1: done pulse from the pass controller.
- `pass_op_config` out 32: `{op_config_q[31:1], pass_start}`.
- `pass_mapping_param`, `pass_shape_param1`, `pass_shape_param2` out 32 each: latched copies.
- `pass_filter_baseaddr`, `pass_ifmap_baseaddr`, `pass_bias_baseaddr`, `pass_opsum_baseaddr` out 32 each: per-pass bases.
- `bias_ipsum_sel` out 1: 1 selects bias, 0 selects accumulate (ipsum).
- `m_idx`, `c_idx` out TILE_BITS each: current tile indices.
- `busy` out 1: high in every state except IDLE.
- `layer_done` out 1: one-cycle pulse when the layer completes.
- `pass_count` out 16: passes completed in the current or last layer.
- `layer_cycles` out 32: cycles spent not in IDLE during the current or last layer; saturates at `32'hFFFF_FFFF`.

## Operation
- **States:** IDLE, ISSUE, WAIT, ADVANCE, DONE.
- **IDLE:**
  - On `layer_start`, latch all configuration, counts, bases and strides.
  - Clear `m_idx`, `c_idx`, `pass_count`, `layer_cycles`.
  - If either count is 0, go to DONE (no pass is issued). Otherwise go to ISSUE.
- **ISSUE:** `pass_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** stay until `pass_done`=1, then go to ADVANCE. `pass_done` is ignored in every other state.
- **ADVANCE:**
  - `pass_count`++.
  - If `c_idx` ≠ `num_c_tiles`−1: `c_idx`++.
  - Else `c_idx`←0. Then if `m_idx` = `num_m_tiles`−1, go to DONE; else `m_idx`++.
  - Otherwise go to ISSUE.
- **DONE:** `layer_done`=1 for one cycle, then go to IDLE.
- **Loop order:** m is the outer loop, c the inner loop.
- **Per-pass addresses** (all modulo 2^32, wrap silently):
  - filter = `filter_base` + (`m_idx`·`num_c_tiles` + `c_idx`)·`filter_tile_bytes`
  - ifmap = `ifmap_base` + `c_idx`·`ifmap_tile_bytes`
  - bias = `bias_base` + `m_idx`·`bias_tile_bytes`
  - opsum = `opsum_base` + `m_idx`·`opsum_tile_bytes`
  - Maintain these as registered running sums updated in ADVANCE, not with multipliers.
- `bias_ipsum_sel` = (`c_idx` == 0).
- All `pass_*` outputs are stable from ISSUE through the end of WAIT.
- `layer_start` while `busy` is ignored.
- Input changes after latching have no effect until the next layer.

## Timing
- **Reset:**
  - State IDLE.
  - Indices, counts, addresses and `layer_cycles` = 0.
  - `pass_start`, `layer_done`, `busy` = 0.
  - `bias_ipsum_sel` = 1 (since `c_idx` = 0).
  - `pass_op_config` = 0.
- Reset mid-pass returns to IDLE immediately. No `layer_done` is produced.
- `layer_start` sampled at edge k: ISSUE (and `pass_start`) during cycle k+1; WAIT from k+2.
- `pass_done` sampled at edge j: ADVANCE during j+1, then ISSUE or DONE during j+2.
- Inter-pass gap: exactly 2 cycles from `pass_done` to the next `pass_start`.
- Zero-count layer: `layer_done` during k+1.
- `busy` and `layer_cycles` are active for every cycle in ISSUE, WAIT, ADVANCE and DONE.
- Outputs are registered or decoded from registered state; there is no combinational path from `pass_done` to outputs.

## Test plan
- **Single pass:** m=1, c=1, bases 0x100/0x200/0x300/0x400; `layer_start` at edge 0.
  - `pass_start` in cycle 1, `bias_ipsum_sel`=1, addresses equal the bases.
  - `pass_done` at edge 10 → `layer_done` in cycle 12, `pass_count`=1.
- **Tiled layer:** m=2, c=3, filter stride 0x40, ifmap stride 0x80, bias stride 0x10, opsum stride 0x1000.
  - Six `pass_start` pulses.
  - Filter addresses base+0x000, 0x040, … 0x140.
  - `bias_ipsum_sel` sequence 1,0,0,1,0,0.
  - Opsum address is base for passes 1–3 and base+0x1000 for passes 4–6.
  - `pass_count`=6 at the end.
- **Zero tiles:** m=0 or c=0 → no `pass_start`; `layer_done` one cycle after start; `pass_count`=0.
- **Ignored events:**
  - `layer_start` pulsed during WAIT → no effect.
  - `pass_done` during ISSUE or ADVANCE → no state change.
  - Changing `filter_base` mid-layer → outputs unchanged.
- **Reset mid-WAIT:** assert `rst` during pass 2 → all outputs at reset values, no `layer_done`; a new `layer_start` replays the full sequence from pass 1.
- **Wrap:** `filter_base`=0xFFFF_FFF0, stride 0x20, c=2 → second filter address 0x0000_0010.

Source files
------------

// File: rtl/pass_scheduler.sv
// pass_scheduler: layer-level sequencer above the per-pass PE-array controller.
// Splits a layer into num_m_tiles x num_c_tiles passes (m outer, c inner). For
// each pass it presents the latched configuration and the per-pass base
// addresses, pulses the start bit and waits for pass_done.
// Ports:
//   clk, rst                      clock, async active-high reset
//   layer_start                   launch a layer (sampled only while idle)
//   op_config..shape_param2       layer configuration, latched at launch
//   num_m_tiles, num_c_tiles      pass counts, latched at launch
//   *_base, *_tile_bytes          region bases and per-tile strides, latched
//   pass_done                     completion pulse from the pass controller
//   pass_*                        per-pass configuration / base addresses
//   bias_ipsum_sel                1 = load bias, 0 = accumulate ipsum
//   m_idx, c_idx                  current tile indices
//   busy, layer_done              status; layer_done pulses once per layer
//   pass_count, layer_cycles      passes completed / non-idle cycles (saturating)
module pass_scheduler #(
   parameter int unsigned TILE_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 layer_start,
   input  logic [31:0]          op_config,
   input  logic [31:0]          mapping_param,
   input  logic [31:0]          shape_param1,
   input  logic [31:0]          shape_param2,
   input  logic [TILE_BITS-1:0] num_m_tiles,
   input  logic [TILE_BITS-1:0] num_c_tiles,
   input  logic [31:0]          filter_base,
   input  logic [31:0]          ifmap_base,
   input  logic [31:0]          bias_base,
   input  logic [31:0]          opsum_base,
   input  logic [31:0]          filter_tile_bytes,
   input  logic [31:0]          ifmap_tile_bytes,
   input  logic [31:0]          bias_tile_bytes,
   input  logic [31:0]          opsum_tile_bytes,
   input  logic                 pass_done,
   output logic [31:0]          pass_op_config,
   output logic [31:0]          pass_mapping_param,
   output logic [31:0]          pass_shape_param1,
   output logic [31:0]          pass_shape_param2,
   output logic [31:0]          pass_filter_baseaddr,
   output logic [31:0]          pass_ifmap_baseaddr,
   output logic [31:0]          pass_bias_baseaddr,
   output logic [31:0]          pass_opsum_baseaddr,
   output logic                 bias_ipsum_sel,
   output logic [TILE_BITS-1:0] m_idx,
   output logic [TILE_BITS-1:0] c_idx,
   output logic                 busy,
   output logic                 layer_done,
   output logic [15:0]          pass_count,
   output logic [31:0]          layer_cycles
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned CYC_W = 32;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_ADVANCE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic                 pass_start;
   logic [30:0]          op_cfg_q;
   logic [31:0]          map_q;
   logic [31:0]          shp1_q;
   logic [31:0]          shp2_q;
   logic [TILE_BITS-1:0] num_m_q;
   logic [TILE_BITS-1:0] num_c_q;
   logic [31:0]          ifmap_base_q;
   logic [31:0]          filt_stride_q;
   logic [31:0]          ifmap_stride_q;
   logic [31:0]          bias_stride_q;
   logic [31:0]          opsum_stride_q;
   logic [31:0]          filt_addr_q;
   logic [31:0]          ifmap_addr_q;
   logic [31:0]          bias_addr_q;
   logic [31:0]          opsum_addr_q;
   logic                 launch;
   logic                 zero_tiles;
   logic                 last_c;
   logic                 last_m;
   logic                 unused_op_lsb;

   // The op_config LSB is replaced by the start strobe on the way out.
   assign unused_op_lsb = op_config[0];

   assign launch     = (state_q == S_IDLE) && layer_start;
   assign zero_tiles = (num_m_tiles == '0) || (num_c_tiles == '0);
   assign last_c     = (c_idx == (num_c_q - TILE_BITS'(1)));
   assign last_m     = (m_idx == (num_m_q - TILE_BITS'(1)));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (layer_start) state_d = zero_tiles ? S_DONE : S_ISSUE;
         end
         S_ISSUE:   state_d = S_WAIT;
         S_WAIT: begin
            if (pass_done) state_d = S_ADVANCE;
         end
         S_ADVANCE: state_d = (last_c && last_m) ? S_DONE : S_ISSUE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State-decoded strobes and status
   always_comb begin
      pass_start = 1'b0;
      layer_done = 1'b0;
      busy       = 1'b1;
      case (state_q)
         S_IDLE:  busy       = 1'b0;
         S_ISSUE: pass_start = 1'b1;
         S_DONE:  layer_done = 1'b1;
         default: ;
      endcase
   end

   // Latched layer context, indices and running base addresses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_cfg_q       <= '0;
         map_q          <= '0;
         shp1_q         <= '0;
         shp2_q         <= '0;
         num_m_q        <= '0;
         num_c_q        <= '0;
         ifmap_base_q   <= '0;
         filt_stride_q  <= '0;
         ifmap_stride_q <= '0;
         bias_stride_q  <= '0;
         opsum_stride_q <= '0;
         filt_addr_q    <= '0;
         ifmap_addr_q   <= '0;
         bias_addr_q    <= '0;
         opsum_addr_q   <= '0;
         m_idx          <= '0;
         c_idx          <= '0;
         pass_count     <= '0;
      end else if (launch) begin
         op_cfg_q       <= op_config[31:1];
         map_q          <= mapping_param;
         shp1_q         <= shape_param1;
         shp2_q         <= shape_param2;
         num_m_q        <= num_m_tiles;
         num_c_q        <= num_c_tiles;
         ifmap_base_q   <= ifmap_base;
         filt_stride_q  <= filter_tile_bytes;
         ifmap_stride_q <= ifmap_tile_bytes;
         bias_stride_q  <= bias_tile_bytes;
         opsum_stride_q <= opsum_tile_bytes;
         filt_addr_q    <= filter_base;
         ifmap_addr_q   <= ifmap_base;
         bias_addr_q    <= bias_base;
         opsum_addr_q   <= opsum_base;
         m_idx          <= '0;
         c_idx          <= '0;
         pass_count     <= '0;
      end else if (state_q == S_ADVANCE) begin
         pass_count  <= pass_count + CNT_W'(1);
         // Filter tiles are laid out in pass order, so one stride per pass.
         filt_addr_q <= filt_addr_q + filt_stride_q;
         if (!last_c) begin
            c_idx        <= c_idx + TILE_BITS'(1);
            ifmap_addr_q <= ifmap_addr_q + ifmap_stride_q;
         end else begin
            c_idx        <= '0;
            ifmap_addr_q <= ifmap_base_q;
            if (!last_m) begin
               m_idx        <= m_idx + TILE_BITS'(1);
               bias_addr_q  <= bias_addr_q + bias_stride_q;
               opsum_addr_q <= opsum_addr_q + opsum_stride_q;
            end
         end
      end
   end

   // Non-idle cycle counter, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         layer_cycles <= '0;
      end else if (launch) begin
         layer_cycles <= '0;
      end else if ((state_q != S_IDLE) && (layer_cycles != '1)) begin
         layer_cycles <= layer_cycles + CYC_W'(1);
      end
   end

   assign pass_op_config       = {op_cfg_q, pass_start};
   assign pass_mapping_param   = map_q;
   assign pass_shape_param1    = shp1_q;
   assign pass_shape_param2    = shp2_q;
   assign pass_filter_baseaddr = filt_addr_q;
   assign pass_ifmap_baseaddr  = ifmap_addr_q;
   assign pass_bias_baseaddr   = bias_addr_q;
   assign pass_opsum_baseaddr  = opsum_addr_q;
   assign bias_ipsum_sel       = (c_idx == '0);

endmodule

// File: tb/tb_pass_scheduler.sv
// tb_pass_scheduler: directed bench for pass_scheduler. A timeline model
// (periods at which each pass must start and the layer must finish, tile
// indices and addresses from the closed-form formulas) is checked against the
// DUT every cycle; literal tables pin the model for each scenario.
module tb_pass_scheduler;

   localparam int unsigned TB_TILE = 8;
   localparam int          NONE    = -1;
   localparam int          INF     = 32'h7FFF_FFFF;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               layer_start = 1'b0;
   logic               pass_done = 1'b0;
   logic [31:0]        op_config = '0, mapping_param = '0, shape_param1 = '0, shape_param2 = '0;
   logic [TB_TILE-1:0] num_m_tiles = '0, num_c_tiles = '0;
   logic [31:0]        filter_base = '0, ifmap_base = '0, bias_base = '0, opsum_base = '0;
   logic [31:0]        filter_tile_bytes = '0, ifmap_tile_bytes = '0;
   logic [31:0]        bias_tile_bytes = '0, opsum_tile_bytes = '0;

   logic [31:0]        pass_op_config, pass_mapping_param, pass_shape_param1, pass_shape_param2;
   logic [31:0]        pass_filter_baseaddr, pass_ifmap_baseaddr, pass_bias_baseaddr, pass_opsum_baseaddr;
   logic               bias_ipsum_sel, busy, layer_done;
   logic [TB_TILE-1:0] m_idx, c_idx;
   logic [15:0]        pass_count;
   logic [31:0]        layer_cycles;

   pass_scheduler #(.TILE_BITS(TB_TILE)) dut (
      .clk(clk), .rst(rst), .layer_start(layer_start),
      .op_config(op_config), .mapping_param(mapping_param),
      .shape_param1(shape_param1), .shape_param2(shape_param2),
      .num_m_tiles(num_m_tiles), .num_c_tiles(num_c_tiles),
      .filter_base(filter_base), .ifmap_base(ifmap_base),
      .bias_base(bias_base), .opsum_base(opsum_base),
      .filter_tile_bytes(filter_tile_bytes), .ifmap_tile_bytes(ifmap_tile_bytes),
      .bias_tile_bytes(bias_tile_bytes), .opsum_tile_bytes(opsum_tile_bytes),
      .pass_done(pass_done),
      .pass_op_config(pass_op_config), .pass_mapping_param(pass_mapping_param),
      .pass_shape_param1(pass_shape_param1), .pass_shape_param2(pass_shape_param2),
      .pass_filter_baseaddr(pass_filter_baseaddr), .pass_ifmap_baseaddr(pass_ifmap_baseaddr),
      .pass_bias_baseaddr(pass_bias_baseaddr), .pass_opsum_baseaddr(pass_opsum_baseaddr),
      .bias_ipsum_sel(bias_ipsum_sel), .m_idx(m_idx), .c_idx(c_idx),
      .busy(busy), .layer_done(layer_done),
      .pass_count(pass_count), .layer_cycles(layer_cycles)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int per    = 0;   // index of the clock period following the latest rising edge

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (period %0d)", name, act, exp, per);
   endfunction

   // ---------------- timeline model ----------------
   int          t_start = NONE, t_issue = NONE, t_done = NONE, t_last = NONE;
   int          bump_at = NONE, pc = 0, total = 0;
   bit          wt = 1'b0;     // a pass has been scheduled and its done is still owed
   logic [31:0] m_op, m_map, m_s1, m_s2, m_fb, m_fs, m_ib, m_is, m_bb, m_bs, m_ob, m_os;
   int          m_M, m_C;

   always @(posedge clk) begin
      bit prev_busy;
      per = per + 1;
      if (rst) begin
         t_start = NONE; t_issue = NONE; t_done = NONE; t_last = NONE;
         bump_at = NONE; pc = 0; wt = 1'b0;
      end else begin
         prev_busy = (t_start >= 0) && (per - 1 >= t_start) && (per - 1 <= t_last);
         if (per == bump_at) pc = pc + 1;
         if (!prev_busy && layer_start) begin
            m_op = op_config; m_map = mapping_param; m_s1 = shape_param1; m_s2 = shape_param2;
            m_fb = filter_base; m_fs = filter_tile_bytes; m_ib = ifmap_base; m_is = ifmap_tile_bytes;
            m_bb = bias_base; m_bs = bias_tile_bytes; m_ob = opsum_base; m_os = opsum_tile_bytes;
            m_M = int'(num_m_tiles); m_C = int'(num_c_tiles);
            total = m_M * m_C; t_start = per; pc = 0; bump_at = NONE;
            if (total == 0) begin
               t_issue = NONE; t_done = per; t_last = per; wt = 1'b0;
            end else begin
               t_issue = per; t_done = NONE; t_last = INF; wt = 1'b1;
            end
         end else if (prev_busy && wt && (per - 1 > t_issue) && pass_done) begin
            // done accepted: one bookkeeping period, then next start or layer end
            wt = 1'b0; bump_at = per + 1;
            if (pc + 1 == total) begin
               t_done = per + 1; t_last = per + 1;
            end else begin
               t_issue = per + 1; wt = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      int q, mm, cc;
      bit busy_e;
      q = per;
      if (rst) begin
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_layer_done", 32'(layer_done), 32'd0);
         chk("rst_op_config", pass_op_config, 32'd0);
         chk("rst_mapping", pass_mapping_param, 32'd0);
         chk("rst_idx", 32'({m_idx, c_idx}), 32'd0);
         chk("rst_bias_sel", 32'(bias_ipsum_sel), 32'd1);
         chk("rst_pass_count", 32'(pass_count), 32'd0);
         chk("rst_layer_cycles", layer_cycles, 32'd0);
         chk("rst_filter", pass_filter_baseaddr, 32'd0);
         chk("rst_ifmap", pass_ifmap_baseaddr, 32'd0);
         chk("rst_bias", pass_bias_baseaddr, 32'd0);
         chk("rst_opsum", pass_opsum_baseaddr, 32'd0);
      end else begin
         busy_e = (t_start >= 0) && (q >= t_start) && (q <= t_last);
         chk("busy", 32'(busy), 32'(busy_e));
         chk("pass_start", 32'(pass_op_config[0]), 32'(q == t_issue));
         chk("layer_done", 32'(layer_done), 32'(q == t_done));
         chk("pass_count", 32'(pass_count), 32'(pc));
         chk("layer_cycles", layer_cycles,
             busy_e ? 32'(q - t_start) : ((t_start < 0) ? 32'd0 : 32'(t_last - t_start + 1)));
         if (wt && q >= t_issue) begin
            mm = pc / m_C;
            cc = pc % m_C;
            chk("m_idx", 32'(m_idx), 32'(mm));
            chk("c_idx", 32'(c_idx), 32'(cc));
            chk("bias_sel", 32'(bias_ipsum_sel), 32'(cc == 0));
            chk("op_config", pass_op_config, {m_op[31:1], (q == t_issue)});
            chk("mapping", pass_mapping_param, m_map);
            chk("shape1", pass_shape_param1, m_s1);
            chk("shape2", pass_shape_param2, m_s2);
            chk("filter_addr", pass_filter_baseaddr, m_fb + 32'(mm * m_C + cc) * m_fs);
            chk("ifmap_addr", pass_ifmap_baseaddr, m_ib + 32'(cc) * m_is);
            chk("bias_addr", pass_bias_baseaddr, m_bb + 32'(mm) * m_bs);
            chk("opsum_addr", pass_opsum_baseaddr, m_ob + 32'(mm) * m_os);
         end
      end
   end

   // ---------------- capture of pass starts / layer_done ----------------
   logic [31:0] cap_f[$], cap_o[$];
   bit          cap_sel[$];
   int          cap_per[$];
   int          done_per = NONE;
   int          ld_count = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (pass_op_config[0]) begin
            cap_f.push_back(pass_filter_baseaddr);
            cap_o.push_back(pass_opsum_baseaddr);
            cap_sel.push_back(bias_ipsum_sel);
            cap_per.push_back(per);
         end
         if (layer_done) begin
            done_per = per;
            ld_count++;
         end
      end
   end

   function automatic logic [31:0] capf(input int i);
      return (cap_f.size() > i) ? cap_f[i] : 32'hBAD0_BAD0;
   endfunction
   function automatic logic [31:0] capo(input int i);
      return (cap_o.size() > i) ? cap_o[i] : 32'hBAD0_BAD0;
   endfunction
   function automatic logic [31:0] caps(input int i);
      return (cap_sel.size() > i) ? 32'(cap_sel[i]) : 32'hBAD0_BAD0;
   endfunction

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic cfg(input int m, input int c,
                      input logic [31:0] fb, input logic [31:0] fs, input logic [31:0] ib, input logic [31:0] is_,
                      input logic [31:0] bb, input logic [31:0] bs, input logic [31:0] ob, input logic [31:0] os);
      num_m_tiles = TB_TILE'(m); num_c_tiles = TB_TILE'(c);
      filter_base = fb; filter_tile_bytes = fs; ifmap_base = ib; ifmap_tile_bytes = is_;
      bias_base = bb; bias_tile_bytes = bs; opsum_base = ob; opsum_tile_bytes = os;
      op_config = 32'hA5A5_0003 + 32'(m * 16 + c);
      mapping_param = 32'h1111_0000 + 32'(m);
      shape_param1 = 32'h2222_0000 + 32'(c);
      shape_param2 = 32'h3333_0000;
   endtask

   task automatic start_layer(output int s);
      cap_f.delete(); cap_o.delete(); cap_sel.delete(); cap_per.delete();
      done_per = NONE;
      layer_start = 1'b1;
      tick();
      layer_start = 1'b0;
      s = per;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (pass_op_config[0]) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
      chk("pass_start_seen", 32'(pass_op_config[0]), 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (!busy) return;
         tick();
      end
      chk("busy_drop", 32'(busy), 32'd0);
   endtask

   // Answer npass passes; pass_done lands d periods after each pass_start.
   task automatic serve(input int npass, input int d, input bit noisy, input int rst_pass);
      bit ok;
      int k;
      for (int p = 0; p < npass; p++) begin
         wait_start(ok);
         if (!ok) return;
         k = 1;
         if (noisy && p == 1) begin
            pass_done   = 1'b1;
            filter_base = ~filter_base;
         end
         tick();
         pass_done = 1'b0;
         if (p == rst_pass) begin
            rst = 1'b1;
            tick(); tick();
            rst = 1'b0;
            return;
         end
         if (noisy && p == 1) begin
            layer_start = 1'b1;
            tick();
            layer_start = 1'b0;
            k = 2;
         end
         repeat (d - k) tick();
         pass_done = 1'b1;
         tick();
         if (noisy && p == 1) tick();
         pass_done = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s, ld_before;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // single pass
      cfg(1, 1, 32'h100, 32'h0, 32'h200, 32'h0, 32'h300, 32'h0, 32'h400, 32'h0);
      start_layer(s);
      serve(1, 9, 1'b0, NONE);
      wait_idle();
      chk("single_starts", 32'(cap_f.size()), 32'd1);
      chk("single_start_period", 32'(((cap_per.size() > 0) ? cap_per[0] : NONE) - s), 32'd0);
      chk("single_filter", capf(0), 32'h100);
      chk("single_opsum", capo(0), 32'h400);
      chk("single_sel", caps(0), 32'd1);
      chk("single_done_period", 32'(done_per - s), 32'd11);
      chk("single_count", 32'(pass_count), 32'd1);
      chk("single_cycles", layer_cycles, 32'd12);
      tick();

      // tiled layer with ignored events in pass 2
      cfg(2, 3, 32'h1000_0000, 32'h40, 32'h2000_0000, 32'h80,
          32'h3000_0000, 32'h10, 32'h4000_0000, 32'h1000);
      start_layer(s);
      serve(6, 4, 1'b1, NONE);
      wait_idle();
      chk("tiled_starts", 32'(cap_f.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk("tiled_filter", capf(i), 32'h1000_0000 + 32'(i * 64));
         chk("tiled_sel", caps(i), (i % 3 == 0) ? 32'd1 : 32'd0);
         chk("tiled_opsum", capo(i), (i < 3) ? 32'h4000_0000 : 32'h4000_1000);
      end
      chk("tiled_count", 32'(pass_count), 32'd6);
      tick();

      // zero tiles
      cfg(0, 3, 32'h10, 32'h10, 32'h20, 32'h20, 32'h30, 32'h30, 32'h40, 32'h40);
      start_layer(s);
      wait_idle();
      chk("zero_m_starts", 32'(cap_f.size()), 32'd0);
      chk("zero_m_done_period", 32'(done_per - s), 32'd0);
      chk("zero_m_count", 32'(pass_count), 32'd0);
      tick();
      cfg(2, 0, 32'h10, 32'h10, 32'h20, 32'h20, 32'h30, 32'h30, 32'h40, 32'h40);
      start_layer(s);
      wait_idle();
      chk("zero_c_starts", 32'(cap_f.size()), 32'd0);
      chk("zero_c_done_period", 32'(done_per - s), 32'd0);
      tick();

      // reset during pass 2, then a full replay
      cfg(2, 3, 32'h5000_0000, 32'h40, 32'h6000_0000, 32'h80,
          32'h7000_0000, 32'h10, 32'h8000_0000, 32'h1000);
      start_layer(s);
      ld_before = ld_count;
      serve(6, 5, 1'b0, 1);
      wait_idle();
      chk("rst_no_layer_done", 32'(ld_count), 32'(ld_before));
      chk("rst_starts_before", 32'(cap_f.size()), 32'd2);
      tick();
      start_layer(s);
      serve(6, 3, 1'b0, NONE);
      wait_idle();
      chk("replay_starts", 32'(cap_f.size()), 32'd6);
      chk("replay_first_filter", capf(0), 32'h5000_0000);
      chk("replay_last_opsum", capo(5), 32'h8000_1000);
      chk("replay_count", 32'(pass_count), 32'd6);
      tick();

      // address wrap
      cfg(1, 2, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h8, 32'h0, 32'h4, 32'h0, 32'h4);
      start_layer(s);
      serve(2, 3, 1'b0, NONE);
      wait_idle();
      chk("wrap_first", capf(0), 32'hFFFF_FFF0);
      chk("wrap_second", capf(1), 32'h0000_0010);
      chk("wrap_sel", caps(1), 32'd0);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
